// File: rtl/alu_pwr_seq.sv
// Power sequencer for the power-gated ALU: orders power-switch and isolation
// control, captures the clamp value on shutdown and gates operation starts.
module alu_pwr_seq #(
  parameter int          ISO_DLY      = 2,
  parameter int          PWR_DLY      = 3,
  parameter logic [15:0] IDLE_TIMEOUT = 16'd16,
  parameter bit          AUTO_WAKE    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sleep_req,
  input  logic        wake_req,
  input  logic        start_in,
  input  logic        alu_busy,
  input  logic [15:0] alu_result,
  output logic        alu_pwr_en,
  output logic        iso_en,
  output logic [15:0] clamp_value,
  output logic        start_out,
  output logic        start_drop,
  output logic        ready,
  output logic [1:0]  pwr_state
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_PWR_UP = 2'd1,
    ST_ON     = 2'd2,
    ST_ISO_ON = 2'd3
  } state_t;

  localparam logic [15:0] ISO_LOAD = 16'(ISO_DLY - 1);
  localparam logic [15:0] PWR_LOAD = 16'(PWR_DLY - 1);

  state_t      state;
  logic [15:0] dly_cnt;
  logic [15:0] idle_cnt;

  logic is_on;
  logic idle_cycle;
  logic timed_out;
  logic sleep_cond;
  logic wake_cond;

  assign is_on      = (state == ST_ON);
  assign idle_cycle = !start_in && !alu_busy && !wake_req;
  assign timed_out  = (IDLE_TIMEOUT != 16'd0) && (idle_cnt == IDLE_TIMEOUT);
  // Wake, start and a busy ALU all veto sleep, so sleep needs a fully idle cycle.
  assign sleep_cond = (sleep_req || timed_out) && idle_cycle;
  assign wake_cond  = wake_req || (AUTO_WAKE && start_in);

  assign start_out  = start_in && is_on;
  assign start_drop = start_in && !is_on;
  assign ready      = is_on;
  assign pwr_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_OFF;
      alu_pwr_en  <= 1'b0;
      iso_en      <= 1'b1;
      clamp_value <= 16'd0;
      dly_cnt     <= 16'd0;
      idle_cnt    <= 16'd0;
    end else begin
      case (state)
        ST_OFF: begin
          if (wake_cond) begin
            state      <= ST_PWR_UP;
            alu_pwr_en <= 1'b1;
            dly_cnt    <= PWR_LOAD;
          end
        end
        ST_PWR_UP: begin
          if (dly_cnt == 16'd0) begin
            state    <= ST_ON;
            iso_en   <= 1'b0;
            idle_cnt <= 16'd0;
          end else begin
            dly_cnt <= dly_cnt - 16'd1;
          end
        end
        ST_ON: begin
          if (sleep_cond) begin
            state       <= ST_ISO_ON;
            iso_en      <= 1'b1;
            clamp_value <= alu_result;
            dly_cnt     <= ISO_LOAD;
            idle_cnt    <= 16'd0;
          end else if (!idle_cycle) begin
            idle_cnt <= 16'd0;
          end else if (idle_cnt != IDLE_TIMEOUT) begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
        ST_ISO_ON: begin
          // Power is removed only after isolation has been held for ISO_DLY cycles.
          if (dly_cnt == 16'd0) begin
            state      <= ST_OFF;
            alu_pwr_en <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt - 16'd1;
          end
        end
        default: begin
          state      <= ST_OFF;
          alu_pwr_en <= 1'b0;
          iso_en     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Directed bench for alu_pwr_seq with default parameters
// (ISO_DLY=2, PWR_DLY=3, IDLE_TIMEOUT=16, AUTO_WAKE=1).
module tb_alu_pwr_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sleep_req, wake_req, start_in, alu_busy;
  logic [15:0] alu_result;
  logic        alu_pwr_en, iso_en, start_out, start_drop, ready;
  logic [15:0] clamp_value;
  logic [1:0]  pwr_state;

  int total = 0;
  int bad   = 0;

  alu_pwr_seq dut (
    .clk(clk), .rst_n(rst_n), .sleep_req(sleep_req), .wake_req(wake_req),
    .start_in(start_in), .alu_busy(alu_busy), .alu_result(alu_result),
    .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .clamp_value(clamp_value),
    .start_out(start_out), .start_drop(start_drop), .ready(ready),
    .pwr_state(pwr_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wake pulse for one edge, then PWR_DLY edges until ON.
  task automatic go_on();
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sleep_req = 0; wake_req = 0; start_in = 0; alu_busy = 0;
    alu_result = 16'h0;
    repeat (2) tick();
    total++; if ({alu_pwr_en, iso_en} !== 2'b01) begin bad++;
      $display("FAIL reset_outputs got pwr/iso=%b%b exp=01", alu_pwr_en, iso_en); end
    total++; if (clamp_value !== 16'h0) begin bad++;
      $display("FAIL reset_clamp got=%h exp=0000", clamp_value); end
    total++; if (pwr_state !== 2'd0 || ready !== 1'b0) begin bad++;
      $display("FAIL reset_state got=%0d ready=%b exp=0/0", pwr_state, ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_wake();
    repeat (4) tick();
    total++; if (pwr_state !== 2'd0 || alu_pwr_en !== 1'b0) begin bad++;
      $display("FAIL idle_off got state=%0d pwr=%b exp=0/0", pwr_state, alu_pwr_en); end
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    total++; if ({alu_pwr_en, iso_en, pwr_state} !== 4'b1101) begin bad++;
      $display("FAIL wake_edge got pwr=%b iso=%b st=%0d exp=1/1/1", alu_pwr_en, iso_en, pwr_state); end
    repeat (2) tick();
    total++; if (iso_en !== 1'b1 || ready !== 1'b0) begin bad++;
      $display("FAIL wake_hold got iso=%b ready=%b exp=1/0", iso_en, ready); end
    tick();
    total++; if ({iso_en, ready, pwr_state} !== 4'b0110) begin bad++;
      $display("FAIL wake_on got iso=%b ready=%b st=%0d exp=0/1/2", iso_en, ready, pwr_state); end
  endtask

  task automatic test_sleep();
    alu_result = 16'hBEEF;
    sleep_req  = 1'b1;
    tick();
    sleep_req  = 1'b0;
    alu_result = 16'h1234;
    total++; if ({alu_pwr_en, iso_en, pwr_state} !== 4'b1111) begin bad++;
      $display("FAIL sleep_iso got pwr=%b iso=%b st=%0d exp=1/1/3", alu_pwr_en, iso_en, pwr_state); end
    total++; if (clamp_value !== 16'hBEEF) begin bad++;
      $display("FAIL sleep_clamp got=%h exp=beef", clamp_value); end
    tick();
    total++; if (alu_pwr_en !== 1'b1) begin bad++;
      $display("FAIL sleep_pwr_hold got=%b exp=1", alu_pwr_en); end
    tick();
    total++; if (alu_pwr_en !== 1'b0 || pwr_state !== 2'd0 || clamp_value !== 16'hBEEF) begin bad++;
      $display("FAIL sleep_off got pwr=%b st=%0d clamp=%h exp=0/0/beef", alu_pwr_en, pwr_state, clamp_value); end
  endtask

  task automatic test_busy_hold();
    int stayed;
    go_on();
    alu_result = 16'h0A5A;
    alu_busy = 1'b1; sleep_req = 1'b1;
    stayed = 0;
    repeat (4) begin tick(); if (pwr_state == 2'd2) stayed++; end
    total++; if (stayed !== 4) begin bad++;
      $display("FAIL busy_hold got on_cycles=%0d exp=4", stayed); end
    alu_busy = 1'b0;
    tick();
    sleep_req = 1'b0;
    total++; if (pwr_state !== 2'd3 || clamp_value !== 16'h0A5A) begin bad++;
      $display("FAIL busy_release got st=%0d clamp=%h exp=3/0a5a", pwr_state, clamp_value); end
    repeat (2) tick();
  endtask

  task automatic test_idle_timeout();
    int stayed;
    go_on();
    stayed = 0;
    repeat (16) begin tick(); if (pwr_state == 2'd2) stayed++; end
    total++; if (stayed !== 16) begin bad++;
      $display("FAIL idle_hold got on_cycles=%0d exp=16", stayed); end
    tick();
    total++; if (pwr_state !== 2'd3) begin bad++;
      $display("FAIL idle_sleep got st=%0d exp=3", pwr_state); end
    repeat (2) tick();
  endtask

  task automatic test_idle_restart();
    int stayed;
    go_on();
    repeat (10) tick();
    start_in = 1'b1;
    #1;
    total++; if (start_out !== 1'b1 || start_drop !== 1'b0) begin bad++;
      $display("FAIL on_start got out=%b drop=%b exp=1/0", start_out, start_drop); end
    tick();
    start_in = 1'b0;
    stayed = 0;
    repeat (16) begin tick(); if (pwr_state == 2'd2) stayed++; end
    total++; if (stayed !== 16) begin bad++;
      $display("FAIL idle_restart_hold got on_cycles=%0d exp=16", stayed); end
    tick();
    total++; if (pwr_state !== 2'd3) begin bad++;
      $display("FAIL idle_restart_sleep got st=%0d exp=3", pwr_state); end
    repeat (2) tick();
  endtask

  task automatic test_auto_wake();
    total++; if (pwr_state !== 2'd0) begin bad++;
      $display("FAIL auto_pre got st=%0d exp=0", pwr_state); end
    start_in = 1'b1;
    #1;
    total++; if (start_drop !== 1'b1 || start_out !== 1'b0) begin bad++;
      $display("FAIL auto_drop got drop=%b out=%b exp=1/0", start_drop, start_out); end
    tick();
    start_in = 1'b0;
    total++; if (pwr_state !== 2'd1 || alu_pwr_en !== 1'b1) begin bad++;
      $display("FAIL auto_pwrup got st=%0d pwr=%b exp=1/1", pwr_state, alu_pwr_en); end
    repeat (3) tick();
    start_in = 1'b1;
    #1;
    total++; if (ready !== 1'b1 || start_out !== 1'b1 || start_drop !== 1'b0) begin bad++;
      $display("FAIL auto_start got ready=%b out=%b drop=%b exp=1/1/0", ready, start_out, start_drop); end
    tick();
    start_in = 1'b0;
  endtask

  task automatic test_sleep_wake_both();
    int stayed;
    sleep_req = 1'b1; wake_req = 1'b1;
    stayed = 0;
    repeat (3) begin tick(); if (pwr_state == 2'd2 && iso_en == 1'b0) stayed++; end
    total++; if (stayed !== 3) begin bad++;
      $display("FAIL both_req got on_cycles=%0d exp=3", stayed); end
    wake_req = 1'b0;
    alu_result = 16'h5A5A;
    tick();
    sleep_req = 1'b0;
    repeat (2) tick();
    total++; if (pwr_state !== 2'd0 || clamp_value !== 16'h5A5A) begin bad++;
      $display("FAIL both_then_sleep got st=%0d clamp=%h exp=0/5a5a", pwr_state, clamp_value); end
  endtask

  task automatic test_reset_mid();
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({alu_pwr_en, iso_en} !== 2'b01 || clamp_value !== 16'h0 || pwr_state !== 2'd0) begin bad++;
      $display("FAIL async_reset got pwr=%b iso=%b clamp=%h st=%0d exp=0/1/0000/0",
               alu_pwr_en, iso_en, clamp_value, pwr_state); end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    total++; if (pwr_state !== 2'd0) begin bad++;
      $display("FAIL post_reset_off got st=%0d exp=0", pwr_state); end
    go_on();
    total++; if (ready !== 1'b1 || iso_en !== 1'b0) begin bad++;
      $display("FAIL post_reset_wake got ready=%b iso=%b exp=1/0", ready, iso_en); end
  endtask

  initial begin
    test_reset();
    test_wake();
    test_sleep();
    test_busy_hold();
    test_idle_timeout();
    test_idle_restart();
    test_auto_wake();
    test_sleep_wake_both();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
